dbus_arbiter: RTL

Two-master arbiter that shares the single data port of the memory/peripheral bridge between the CPU memory stage (master 0) and the DMA engine (master 1). Each cycle it grants at most one request, drives it onto the bridge port, and suppresses writes that the bridge flags with an address exception. It returns read data one cycle later, matching the bridge's registered read path. A streak counter bounds how long the CPU can starve the DMA.

---
 rtl/dbus_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter (m0 = CPU, m1 = DMA): grant/bus drive/exception are same-cycle combinational, loads return 1 cycle later.
// No backpressure: requesters hold req until gnt; m0 has priority, m1 is forced in after MAX_STREAK back-to-back m0 grants.
module dbus_arbiter #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [2:0]  m0_sel,
    output logic        m0_gnt,
    output logic [4:0]  m0_exc,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [2:0]  m1_sel,
    output logic        m1_gnt,
    output logic [4:0]  m1_exc,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic [2:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic [4:0]  bus_exc
);

    localparam logic [3:0] STREAK_CAP = 4'(MAX_STREAK);

    logic [3:0] streak;
    logic       rsp_valid;
    logic       rsp_owner;
    logic       gnt0;
    logic       gnt1;
    logic       granted;
    logic       sel_we;
    logic       exc_ok;

    // Grants are forced low while rst is high so the bus goes idle immediately.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (streak == STREAK_CAP) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    assign granted = gnt0 | gnt1;
    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;

    always_comb begin
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_sel   = 3'b000;
        sel_we    = 1'b0;
        if (gnt0) begin
            bus_addr  = m0_addr;
            bus_wdata = m0_wdata;
            bus_sel   = m0_sel;
            sel_we    = m0_we;
        end else if (gnt1) begin
            bus_addr  = m1_addr;
            bus_wdata = m1_wdata;
            bus_sel   = m1_sel;
            sel_we    = m1_we;
        end
    end

    // bus_sel keeps the store code so the bridge still reports the fault; only the write strobe is dropped.
    assign exc_ok = (bus_exc == 5'd0);
    assign bus_we = sel_we & exc_ok;

    assign m0_exc = gnt0 ? bus_exc : 5'd0;
    assign m1_exc = gnt1 ? bus_exc : 5'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= 4'd0;
        end else if (!m1_req || gnt1) begin
            streak <= 4'd0;
        end else if (gnt0 && (streak != STREAK_CAP)) begin
            streak <= streak + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
        end else begin
            rsp_valid <= granted & ~sel_we & exc_ok;
            rsp_owner <= gnt1;
        end
    end

    // Routing uses the registered owner; this cycle's grant may already belong to the other master.
    assign m0_rvalid = rsp_valid & ~rsp_owner;
    assign m1_rvalid = rsp_valid &  rsp_owner;
    assign m0_rdata  = m0_rvalid ? bus_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? bus_rdata : 32'h0;

endmodule
